// File: rtl/booth_pkg.sv
// Shared types and helpers for the sequential radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold an iteration count from iter down to 0.
    function automatic int cnt_w(input int iter);
        return $clog2(iter + 1);
    endfunction

endpackage

// File: rtl/booth_addsub_shift.sv
// One radix-2 Booth step: conditional add/subtract of M into A, then an
// arithmetic right shift of {A,Q,q_m1} by one bit.
module booth_addsub_shift #(
    parameter int W = 16
) (
    input  logic [W:0]   a,
    input  logic [W-1:0] q,
    input  logic         q_m1,
    input  logic [W:0]   m,
    output logic [W:0]   a_next,
    output logic [W-1:0] q_next,
    output logic         q_m1_next
);

    logic [W:0] sum;

    always_comb begin
        sum = a;
        case ({q[0], q_m1})
            2'b01:   sum = a + m;
            2'b10:   sum = a - m;
            default: sum = a;
        endcase
    end

    assign a_next    = {sum[W], sum[W:1]};
    assign q_next    = {sum[0], q[W-1:1]};
    assign q_m1_next = q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with start/done handshake, one iteration per clock.
// Optional macro BOOTH_UNSIGNED_EN adds a signed_op port selecting signed or unsigned operands.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
`ifdef BOOTH_UNSIGNED_EN
    input  logic                 signed_op,
`endif
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

`ifdef BOOTH_UNSIGNED_EN
    // One guard bit lets unsigned operands be treated as non-negative signed values.
    localparam int QW = WIDTH + 1;
`else
    localparam int QW = WIDTH;
`endif
    localparam int AW   = QW + 1;
    localparam int ITER = QW;
    localparam int CW   = cnt_w(ITER);
    localparam int PA   = 2 * WIDTH - QW;

    state_t               state_reg;
    logic [AW-1:0]        a_reg;
    logic [AW-1:0]        m_reg;
    logic [QW-1:0]        q_reg;
    logic                 q_m1_reg;
    logic [CW-1:0]        count_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic [2*WIDTH-1:0]   product_reg;

    logic                 ext_sign;
    logic [AW-1:0]        m_load;
    logic [QW-1:0]        q_load;
    logic [AW-1:0]        a_next;
    logic [QW-1:0]        q_next;
    logic                 q_m1_next;

`ifdef BOOTH_UNSIGNED_EN
    assign ext_sign = signed_op;
    assign q_load   = {ext_sign & multiplier[WIDTH-1], multiplier};
`else
    assign ext_sign = 1'b1;
    assign q_load   = multiplier;
`endif
    assign m_load = {{(AW - WIDTH){ext_sign & multiplicand[WIDTH-1]}}, multiplicand};

    booth_addsub_shift #(
        .W(QW)
    ) u_step (
        .a         (a_reg),
        .q         (q_reg),
        .q_m1      (q_m1_reg),
        .m         (m_reg),
        .a_next    (a_next),
        .q_next    (q_next),
        .q_m1_next (q_m1_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            m_reg       <= '0;
            q_reg       <= '0;
            q_m1_reg    <= 1'b0;
            count_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            product_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        m_reg     <= m_load;
                        q_reg     <= q_load;
                        a_reg     <= '0;
                        q_m1_reg  <= 1'b0;
                        count_reg <= CW'(ITER);
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    a_reg    <= a_next;
                    q_reg    <= q_next;
                    q_m1_reg <= q_m1_next;
                    if (count_reg != '0) begin
                        count_reg <= count_reg - CW'(1);
                    end
                    // Capture the product from the final step so it is valid with done.
                    if (count_reg == CW'(1)) begin
                        product_reg <= {a_next[PA-1:0], q_next};
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign product = product_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and random checks of booth_mult_seq at WIDTH=16 and WIDTH=8.
module tb_booth_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, start8;
    logic [15:0] mc16, mp16;
    logic [7:0]  mc8, mp8;
    logic        busy16, done16, busy8, done8;
    logic [31:0] prod16;
    logic [15:0] prod8;

`ifdef BOOTH_UNSIGNED_EN
    logic sop16, sop8;
    localparam int LAT = 18;
`else
    localparam int LAT = 17;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk          (clk),
        .rst          (rst),
        .start        (start16),
`ifdef BOOTH_UNSIGNED_EN
        .signed_op    (sop16),
`endif
        .multiplicand (mc16),
        .multiplier   (mp16),
        .busy         (busy16),
        .done         (done16),
        .product      (prod16)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .start        (start8),
`ifdef BOOTH_UNSIGNED_EN
        .signed_op    (sop8),
`endif
        .multiplicand (mc8),
        .multiplier   (mp8),
        .busy         (busy8),
        .done         (done8),
        .product      (prod8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic cur_busy(input bit w8);
        return w8 ? busy8 : busy16;
    endfunction

    function automatic logic cur_done(input bit w8);
        return w8 ? done8 : done16;
    endfunction

    // Called at a negedge; holds start until the DUT accepts it.
    task automatic launch(input bit w8, input logic [15:0] a, input logic [15:0] b, output int edges);
        if (w8) begin
            start8 = 1'b1; mc8 = a[7:0]; mp8 = b[7:0];
        end else begin
            start16 = 1'b1; mc16 = a; mp16 = b;
        end
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!(cur_busy(w8) && !cur_done(w8)) && edges < 8);
        start8  = 1'b0;
        start16 = 1'b0;
        check("accept", 32'(cur_busy(w8)), 32'd1);
    endtask

    // Called just after the accepting edge; lat counts edges from acceptance to done.
    task automatic wait_done(input bit w8, output logic [31:0] p, output int lat, output int busy_lows);
        lat = 1;
        busy_lows = 0;
        @(negedge clk);
        if (!cur_busy(w8)) busy_lows++;
        while (!cur_done(w8) && lat <= 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!cur_busy(w8)) busy_lows++;
        end
        check("done_seen", 32'(cur_done(w8)), 32'd1);
        p = w8 ? {16'h0, prod8} : prod16;
    endtask

    task automatic run(input bit w8, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string tag, output int edges);
        logic [31:0] p;
        int lat, bl;
        launch(w8, a, b, edges);
        wait_done(w8, p, lat, bl);
        check(tag, p, exp);
        $display("mul%0d %h x %h -> %h (exp %h) lat %0d", w8 ? 8 : 16, a, b, p, exp, lat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] p;
        int lat, bl, edges, extra, b2b_bad;

        rst = 1'b1;
        start16 = 1'b0; start8 = 1'b0;
        mc16 = '0; mp16 = '0; mc8 = '0; mp8 = '0;
`ifdef BOOTH_UNSIGNED_EN
        sop16 = 1'b1; sop8 = 1'b1;
`endif
        #12;
        check("rst_busy", 32'(busy16), 32'd0);
        check("rst_done", 32'(done16), 32'd0);
        check("rst_prod16", prod16, 32'd0);
        check("rst_prod8", 32'(prod8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 3 x -4 with latency, busy and done-pulse checks
        launch(1'b0, 16'd3, 16'hFFFC, edges);
        wait_done(1'b0, p, lat, bl);
        check("p_3x-4", p, 32'hFFFF_FFF4);
        check("lat_3x-4", 32'(lat), 32'(LAT));
        check("busy_run", 32'(bl), 32'd0);
        $display("mul16 0003 x fffc -> %h lat %0d", p, lat);
        @(negedge clk);
        check("done_pulse", 32'(done16), 32'd0);
        check("busy_idle", 32'(busy16), 32'd0);
        check("prod_held", prod16, 32'hFFFF_FFF4);

        run(1'b0, 16'h8000, 16'h8000, 32'h4000_0000, "p_min_x_min", edges);
        run(1'b0, 16'h7FFF, 16'h8000, 32'hC000_8000, "p_max_x_min", edges);
        run(1'b0, 16'h0000, 16'h1234, 32'h0000_0000, "p_zero", edges);
        run(1'b0, 16'hFFFF, 16'hFFFF, 32'h0000_0001, "p_m1_x_m1", edges);
        run(1'b1, 16'h0080, 16'h0080, 32'h0000_4000, "p8_min_x_min", edges);
        run(1'b1, 16'h007F, 16'h0080, 32'h0000_C080, "p8_max_x_min", edges);

        // start pulsed mid-RUN with different operands must be ignored
        @(negedge clk);
        launch(1'b0, 16'd100, 16'd200, edges);
        repeat (4) @(negedge clk);
        start16 = 1'b1; mc16 = 16'd9; mp16 = 16'd9;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        wait_done(1'b0, p, lat, bl);
        check("p_ignore_start", p, 32'h0000_4E20);
        $display("mul16 0064 x 00c8 (restart ignored) -> %h", p);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done16) extra++;
        end
        check("single_done", 32'(extra), 32'd0);

        // asynchronous reset between edges aborts the operation
        launch(1'b0, 16'h1234, 16'h0011, edges);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy16), 32'd0);
        check("arst_done", 32'(done16), 32'd0);
        check("arst_prod", prod16, 32'd0);
        $display("reset mid-run: busy %b done %b product %h", busy16, done16, prod16);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run(1'b0, 16'd5, 16'd7, 32'd35, "p_after_rst", edges);

`ifdef BOOTH_UNSIGNED_EN
        sop16 = 1'b0;
        launch(1'b0, 16'hFFFF, 16'hFFFF, edges);
        wait_done(1'b0, p, lat, bl);
        check("p_unsigned", p, 32'hFFFE_0001);
        check("lat_unsigned", 32'(lat), 32'd18);
        $display("mul16 unsigned ffff x ffff -> %h lat %0d", p, lat);
        sop16 = 1'b1;
        run(1'b0, 16'hFFFF, 16'hFFFF, 32'h0000_0001, "p_signed_op", edges);
`endif

        // random pairs, each started during the previous done cycle
        for (int w = 0; w < 2; w++) begin
            b2b_bad = 0;
            @(negedge clk);
            for (int i = 0; i < 1000; i++) begin
                logic [15:0] a, b;
                int sa, sb, prod;
                a = 16'($urandom);
                b = 16'($urandom);
                if (w == 1) begin
                    sa = int'($signed(a[7:0]));
                    sb = int'($signed(b[7:0]));
                    prod = sa * sb;
                    run(1'b1, a, b, {16'h0, prod[15:0]}, "rand8", edges);
                end else begin
                    sa = int'($signed(a));
                    sb = int'($signed(b));
                    prod = sa * sb;
                    run(1'b0, a, b, prod, "rand16", edges);
                end
                if (i > 0 && edges != 2) b2b_bad++;
            end
            check(w == 1 ? "b2b_accept8" : "b2b_accept16", 32'(b2b_bad), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
